// File: rtl/slice_pkg.sv
// Shared slice datapath definitions: arithmetic width, saturation limits and sample type.
`default_nettype none

package slice_pkg;

  localparam int ADD_SUB_WIDTH = 24;

  localparam logic [ADD_SUB_WIDTH-1:0] FULL_POS = {1'b0, {(ADD_SUB_WIDTH-1){1'b1}}};
  localparam logic [ADD_SUB_WIDTH-1:0] FULL_NEG = {1'b1, {(ADD_SUB_WIDTH-1){1'b0}}};

  typedef logic signed [ADD_SUB_WIDTH-1:0] sample_t;

endpackage

`default_nettype wire

// File: rtl/add_sub_24bit_comb_core.sv
// add_sub_core: purely combinational two's-complement add/subtract with signed overflow detect.
`default_nettype none

module add_sub_core #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             add_sub,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] carry_in;

  // Subtraction as a + ~b + 1 keeps a single adder for both operations.
  assign b_eff    = add_sub ? b : ~b;
  assign carry_in = {{(WIDTH-1){1'b0}}, ~add_sub};
  assign sum      = a + b_eff + carry_in;

  // Comparing against the effective addend covers both add and subtract rules.
  assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/add_sub_24bit_comb.sv
// add_sub_24bit_comb: combinational add/sub stage with a sticky overflow flag.
// Optional clamping on overflow when ADD_SUB_SATURATE_EN is defined.
`default_nettype none

module add_sub_24bit_comb
  import slice_pkg::*;
#(
  parameter int WIDTH = ADD_SUB_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ClockEn,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  logic             Add_Sub,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow,
  output logic             Overflow_Sticky
);

  logic [WIDTH-1:0] raw_sum;
  logic             raw_ovf;
  logic             sticky_q;

  add_sub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a        (DataA),
    .b        (DataB),
    .add_sub  (Add_Sub),
    .sum      (raw_sum),
    .overflow (raw_ovf)
  );

  assign Overflow = raw_ovf;

`ifdef ADD_SUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // On overflow the true result shares DataA's sign.
  assign Result = raw_ovf ? (DataA[WIDTH-1] ? SAT_NEG : SAT_POS) : raw_sum;
`else
  assign Result = raw_sum;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sticky_q <= 1'b0;
    end else if (ClockEn && raw_ovf) begin
      sticky_q <= 1'b1;
    end
  end

  assign Overflow_Sticky = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_add_sub_24bit_comb.sv
// Directed self-checking bench for add_sub_24bit_comb (both wrap and saturate builds).
`default_nettype none

module tb_add_sub_24bit_comb;

  localparam int W = 24;

  logic         Clock;
  logic         Reset;
  logic         ClockEn;
  logic [W-1:0] DataA;
  logic [W-1:0] DataB;
  logic         Add_Sub;
  logic [W-1:0] Result;
  logic         Overflow;
  logic         Overflow_Sticky;

  int n_vectors;
  int n_miscompares;

  add_sub_24bit_comb #(
    .WIDTH (W)
  ) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .ClockEn         (ClockEn),
    .DataA           (DataA),
    .DataB           (DataB),
    .Add_Sub         (Add_Sub),
    .Result          (Result),
    .Overflow        (Overflow),
    .Overflow_Sticky (Overflow_Sticky)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive operands and let the combinational path settle.
  task automatic apply(input int a, input int b, input logic add);
    logic [31:0] av;
    logic [31:0] bv;
    av = a;
    bv = b;
    DataA   = av[W-1:0];
    DataB   = bv[W-1:0];
    Add_Sub = add;
    #1;
  endtask

  task automatic edge_sample;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    Reset   = 1'b1;
    ClockEn = 1'b0;
    DataA   = '0;
    DataB   = '0;
    Add_Sub = 1'b1;
    repeat (2) edge_sample();
    check("reset_sticky", {31'd0, Overflow_Sticky}, 32'd0);
    Reset = 1'b0;

    // Plain add and subtract
    apply(9485, -7343, 1'b1);
    check("add_9485", {8'd0, Result}, 32'h00085E);
    check("add_9485_ovf", {31'd0, Overflow}, 32'd0);
    apply(4567, -2345, 1'b1);
    check("add_4567", {8'd0, Result}, 32'h0008AE);
    apply(0, 6743, 1'b1);
    check("add_0", {8'd0, Result}, 32'h001A57);
    apply(2142, 2394, 1'b0);
    check("sub_2142", {8'd0, Result}, 32'hFFFF04);
    check("sub_2142_ovf", {31'd0, Overflow}, 32'd0);
    apply(2222, 6468, 1'b0);
    check("sub_2222", {8'd0, Result}, 32'hFFEF6A);

    // Boundaries
    apply(32'h7FFFFF, 1, 1'b1);
    check("pos_ovf_flag", {31'd0, Overflow}, 32'd1);
`ifdef ADD_SUB_SATURATE_EN
    check("pos_ovf_res", {8'd0, Result}, 32'h7FFFFF);
`else
    check("pos_ovf_res", {8'd0, Result}, 32'h800000);
`endif
    apply(32'h800000, 1, 1'b0);
    check("neg_ovf_flag", {31'd0, Overflow}, 32'd1);
`ifdef ADD_SUB_SATURATE_EN
    check("neg_ovf_res", {8'd0, Result}, 32'h800000);
`else
    check("neg_ovf_res", {8'd0, Result}, 32'h7FFFFF);
`endif
    apply(32'h7FFFFF, 32'h800000, 1'b1);
    check("pos_plus_neg_res", {8'd0, Result}, 32'hFFFFFF);
    check("pos_plus_neg_ovf", {31'd0, Overflow}, 32'd0);
    apply(32'h800000, 32'h800000, 1'b1);
    check("neg_plus_neg_ovf", {31'd0, Overflow}, 32'd1);
`ifdef ADD_SUB_SATURATE_EN
    check("neg_plus_neg_res", {8'd0, Result}, 32'h800000);
`else
    check("neg_plus_neg_res", {8'd0, Result}, 32'h000000);
`endif
    apply(0, 32'h800000, 1'b0);
    check("zero_minus_neg_ovf", {31'd0, Overflow}, 32'd1);
`ifdef ADD_SUB_SATURATE_EN
    check("zero_minus_neg_res", {8'd0, Result}, 32'h7FFFFF);
`else
    check("zero_minus_neg_res", {8'd0, Result}, 32'h800000);
`endif
    apply(-1, -1, 1'b0);
    check("neg1_minus_neg1", {8'd0, Result}, 32'h000000);
    check("neg1_minus_neg1_ovf", {31'd0, Overflow}, 32'd0);

    // Sticky flag behaviour
    @(negedge Clock);
    ClockEn = 1'b1;
    apply(100, 200, 1'b1);
    edge_sample();
    check("sticky_no_ovf", {31'd0, Overflow_Sticky}, 32'd0);

    @(negedge Clock);
    ClockEn = 1'b0;
    apply(32'h7FFFFF, 1, 1'b1);
    edge_sample();
    check("sticky_gated", {31'd0, Overflow_Sticky}, 32'd0);

    @(negedge Clock);
    ClockEn = 1'b1;
    edge_sample();
    check("sticky_set", {31'd0, Overflow_Sticky}, 32'd1);

    @(negedge Clock);
    apply(5, 6, 1'b1);
    repeat (3) edge_sample();
    check("sticky_hold", {31'd0, Overflow_Sticky}, 32'd1);

    @(negedge Clock);
    Reset = 1'b1;
    apply(32'h800000, 1, 1'b0);
    check("reset_no_force_ovf", {31'd0, Overflow}, 32'd1);
`ifdef ADD_SUB_SATURATE_EN
    check("reset_no_force_res", {8'd0, Result}, 32'h800000);
`else
    check("reset_no_force_res", {8'd0, Result}, 32'h7FFFFF);
`endif
    edge_sample();
    check("sticky_reset_prio", {31'd0, Overflow_Sticky}, 32'd0);

    @(negedge Clock);
    Reset = 1'b0;
    edge_sample();
    check("sticky_reset_release", {31'd0, Overflow_Sticky}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/add_sub_24bit_comb.md
Name: add_sub_24bit_comb

Overview:
- Signed two's-complement add/subtract stage with no output register; Result and Overflow are purely combinational.
- First stage of the slice datapath: computes state_value ± sign-extended coefficient A. Its output feeds the registered second stage (add_sub_24bit_with_outreg).
- Carries one clocked element only: a sticky overflow status flag for slice-level monitoring.

Parameters:
- WIDTH, 24, operand/result bit width (all arithmetic is WIDTH-bit two's complement).

Ports:
- Clock  input  1  single clock; only the sticky flag is clocked.
- Reset  input  1  synchronous, active-high; clears the sticky flag.
- ClockEn  input  1  enables sticky-flag update.
- DataA  input  WIDTH  signed minuend/augend.
- DataB  input  WIDTH  signed subtrahend/addend. The caller sign-extends narrower coefficients, e.g. 18-bit to 24.
- Add_Sub  input  1  1 = DataA + DataB; 0 = DataA − DataB.
- Result  output  WIDTH  signed result, combinational.
- Overflow  output  1  signed overflow of the current operation, combinational.
- Overflow_Sticky  output  1  registered OR of Overflow since the last Reset.

Behaviour:
- One clock, Clock. Reset is synchronous and active-high, named Reset. Polarity and synchronicity are fixed.
- Result, zero latency:
  - Add_Sub=1: Result = (DataA + DataB) mod 2^WIDTH.
  - Add_Sub=0: Result = (DataA − DataB) mod 2^WIDTH, implemented as DataA + ~DataB + 1.
- Overflow, combinational:
  - Add: DataA[MSB] == DataB[MSB] and Result[MSB] != DataA[MSB].
  - Subtract: DataA[MSB] != DataB[MSB] and Result[MSB] != DataA[MSB].
  - Overflow is computed from the raw wrapped sum, regardless of the optional saturation feature.
- Result and Overflow do not depend on Clock, Reset or ClockEn. Reset does not force them.
- Overflow_Sticky, on each rising Clock edge:
  - Reset=1: clears to 0. Reset has priority over ClockEn.
  - Else ClockEn=1 and Overflow=1: sets to 1.
  - Otherwise: holds its value.
- Overflow_Sticky reset value is 0. It also powers up at 0.
- Boundaries:
  - FULL_NEG − 1 and FULL_POS + 1 overflow.
  - FULL_NEG + FULL_NEG overflows (raw Result 0).
  - 0 − FULL_NEG overflows (raw Result FULL_NEG).
  - FULL_POS + FULL_NEG = −1 with no overflow.
- If Reset is asserted mid-accumulation, the sticky flag is lost; the combinational path is unaffected.

Optional Feature:
- Macro ADD_SUB_SATURATE_EN.
- Defined: when Overflow=1, Result is clamped. Clamp to FULL_POS (0x7FFFFF) if the true result is positive, i.e. DataA[MSB]=0; otherwise clamp to FULL_NEG (0x800000).
- Undefined: Result wraps modulo 2^WIDTH.
- Overflow and Overflow_Sticky behave identically in both builds.

Decomposition:
- Shared package slice_pkg holds:
  - constant ADD_SUB_WIDTH = 24
  - FULL_POS = {1'b0,{WIDTH-1{1'b1}}}
  - FULL_NEG = {1'b1,{WIDTH-1{1'b0}}}
  - typedef sample_t (signed WIDTH)
- One natural sub-module, add_sub_core: purely combinational sum plus overflow detect. It is reusable by the registered stage.
- The top wraps add_sub_core with the saturation mux and the sticky register.

Test Plan:
- Add, Add_Sub=1: DataA=9485, DataB=−7343 → Result=2142, Overflow=0. Then 4567 + (−2345) → 2222. Then 0 + 6743 → 6743. Result changes in the same timestep as the inputs.
- Subtract, Add_Sub=0: DataA=2142, DataB=2394 → Result=−252, Overflow=0. DataA=2222, DataB=6468 → −4246.
- Positive overflow: 0x7FFFFF + 1 → Overflow=1.
  - Result=0x800000 by default.
  - Result=0x7FFFFF with ADD_SUB_SATURATE_EN.
- Negative overflow: 0x800000 − 1 → Overflow=1.
  - Result=0x7FFFFF by default.
  - Result=0x800000 with ADD_SUB_SATURATE_EN.
  - Also check 0x7FFFFF + 0x800000 → 0xFFFFFF, Overflow=0.
- Sticky flag:
  - Apply one overflowing operation with ClockEn=1 → Overflow_Sticky=1 after the next edge, and it holds after the inputs return to non-overflowing.
  - Apply an overflowing operation with ClockEn=0 → the flag does not set.
  - Assert Reset=1 together with ClockEn=1 and an overflow → the flag is 0 after the edge.
